// File: rtl/timer_pkg.sv
`default_nettype none
// ============================================================================
// Module  : timer_pkg
// Brief   : Shared types and helpers for the BCD countdown timer.
// Revision: 1.0 - initial release
// ============================================================================
package timer_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        PAUSE   = 2'd2,
        EXPIRED = 2'd3
    } timer_state_t;

    typedef logic [3:0] bcd_t;

    localparam bcd_t BCD_MAX = 4'd9;

    // Non-decimal nibbles saturate to the largest legal digit
    function automatic bcd_t clamp_bcd(input bcd_t d);
        return (d > BCD_MAX) ? BCD_MAX : d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tick_prescaler.sv
`default_nettype none
// ============================================================================
// Module  : tick_prescaler
// Brief   : Modulo-TICKS enable counter producing a one-cycle tick strobe.
// Revision: 1.0 - initial release
// ============================================================================
module tick_prescaler #(
    parameter int TICKS = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic ena,
    output logic tick
);

    localparam int              c_W    = (TICKS > 1) ? $clog2(TICKS) : 1;
    localparam logic [c_W-1:0]  c_LAST = c_W'(TICKS - 1);

    logic [c_W-1:0] r_count;

    // Counter advances only while enabled, so a freeze keeps the phase intact
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (ena) begin
            if (r_count == c_LAST) begin
                r_count <= '0;
            end else begin
                r_count <= r_count + c_W'(1);
            end
        end
    end

    assign tick = ena && (r_count == c_LAST);

endmodule
`default_nettype wire

// File: rtl/countdown_timer_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : countdown_timer_ctrl
// Brief   : Loadable multi-digit BCD countdown timer with built-in prescaler,
//           pause/resume and expiry flagging.
// Revision: 1.0 - initial release
// ============================================================================
module countdown_timer_ctrl
    import timer_pkg::*;
#(
    parameter int NUM_DIGITS  = 2,
    parameter int CLK_FREQ_HZ = 31_500_000,
    parameter int TICK_HZ     = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    load_req,
    input  logic [4*NUM_DIGITS-1:0] load_value,
    input  logic                    start,
    input  logic                    pause,
    output logic [4*NUM_DIGITS-1:0] digits,
    output logic                    running,
    output logic                    tick_out,
    output logic                    expired,
    output logic                    expire_pulse
);

    localparam int c_TICKS = CLK_FREQ_HZ / TICK_HZ;

    timer_state_t              r_state;
    timer_state_t              w_state_next;
    logic [4*NUM_DIGITS-1:0]   r_digits;
    logic [4*NUM_DIGITS-1:0]   w_dec_value;
    logic [4*NUM_DIGITS-1:0]   w_load_clamped;
    logic [NUM_DIGITS-1:0]     w_borrow;
    logic                      w_dec_zero;
    logic                      w_ena;
    logic                      w_tick;
    logic                      r_running;
    logic                      r_tick_out;
    logic                      r_expired;
    logic                      r_expire_pulse;

    // Prescaler only runs in RUN; pause or a load both freeze it (load also clears it)
    assign w_ena = (r_state == RUN) && !pause && !load_req;

    tick_prescaler #(
        .TICKS (c_TICKS)
    ) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .clr   (load_req),
        .ena   (w_ena),
        .tick  (w_tick)
    );

    // Digit 0 always borrows; higher digits borrow when every lower digit was 0
    assign w_borrow[0] = 1'b1;

    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
        bcd_t w_cur;
        assign w_cur = r_digits[4*i +: 4];
        assign w_dec_value[4*i +: 4] = w_borrow[i] ?
                                       ((w_cur == 4'd0) ? BCD_MAX : (w_cur - 4'd1)) :
                                       w_cur;
        assign w_load_clamped[4*i +: 4] = clamp_bcd(load_value[4*i +: 4]);
        if (i < NUM_DIGITS - 1) begin : g_chain
            assign w_borrow[i+1] = w_borrow[i] && (w_cur == 4'd0);
        end
    end

    assign w_dec_zero = (w_dec_value == '0);

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state: load first, then pause, then start, then tick
    always_comb begin
        w_state_next = r_state;
        if (load_req) begin
            w_state_next = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (!pause && start && (r_digits != '0)) begin
                        w_state_next = RUN;
                    end
                end
                RUN: begin
                    if (pause) begin
                        w_state_next = PAUSE;
                    end else if (w_tick && w_dec_zero) begin
                        w_state_next = EXPIRED;
                    end
                end
                PAUSE: begin
                    if (!pause) begin
                        w_state_next = RUN;
                    end
                end
                EXPIRED: w_state_next = EXPIRED;
                default: w_state_next = IDLE;
            endcase
        end
    end

    // Count register: load wins, otherwise step down on each prescaler tick
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_digits <= '0;
        end else if (load_req) begin
            r_digits <= w_load_clamped;
        end else if (w_tick) begin
            r_digits <= w_dec_value;
        end
    end

    // Status outputs registered from the next state so they align with the digits
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_running      <= 1'b0;
            r_tick_out     <= 1'b0;
            r_expired      <= 1'b0;
            r_expire_pulse <= 1'b0;
        end else begin
            r_running      <= (w_state_next == RUN);
            r_tick_out     <= w_tick;
            r_expired      <= (w_state_next == EXPIRED);
            r_expire_pulse <= (w_state_next == EXPIRED) && (r_state != EXPIRED);
        end
    end

    assign digits       = r_digits;
    assign running      = r_running;
    assign tick_out     = r_tick_out;
    assign expired      = r_expired;
    assign expire_pulse = r_expire_pulse;

endmodule
`default_nettype wire
